rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Shares the register file's single write port (decoder select, data, load enable) between two writeback requesters: ALU result (alu_*) and memory load return (mem_*).
- Each requester has a 1-deep holding slot with a valid/ready handshake.
- Fixed priority favours mem; an anti-starvation counter forces an ALU grant after MAX_WAIT lost cycles.
- Writes to r0 (%g0) are accepted and discarded. Output is registered and drives the register file directly.

Parameters:
- MAX_WAIT, 3, consecutive lost arbitration cycles after which a pending ALU write wins (1..15).
- AW, 5, register address width (fixed 5 for 32 registers).
- DW, 32, data width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU write request
- alu_ready  out  1  ALU slot can accept
- alu_addr  in  5  ALU destination register
- alu_data  in  32  ALU write data
- mem_valid  in  1  load write request
- mem_ready  out  1  mem slot can accept
- mem_addr  in  5  load destination register
- mem_data  in  32  load write data
- rf_addr  out  5  to register file decoder input
- rf_data  out  32  to register file data input
- rf_ld  out  1  to register file load enable
- busy  out  1  any slot valid or rf_ld high

Behaviour:
- Reset (async, rst_n low): both slots invalid; rf_ld=0, rf_addr=0, rf_data=0; wait counter=0; alu_ready=mem_ready=0 while rst_n low; busy=0. Requests in flight at reset are lost.
- Acceptance: transfer when X_valid && X_ready at a rising edge; the slot captures addr/data and is valid from the next cycle.
- X_ready = rst_n && (!slot_X_valid || grant_X). Same-cycle drain+refill is allowed, giving 1 write/cycle/requester throughput.
- Grant (combinational from slot state, one grant max per cycle):
  - no slot valid -> none;
  - only one valid -> that one;
  - both valid -> ALU if wait_cnt==MAX_WAIT, else mem.
- Wait counter:
  - +1 each cycle slot_alu valid and not granted; saturates at MAX_WAIT;
  - cleared on ALU grant or when slot_alu is invalid.
- Output stage (registered):
  - on a grant, rf_addr/rf_data load the granted slot's values and rf_ld <= (addr != 0);
  - with no grant, rf_ld <= 0 and rf_addr/rf_data hold their values.
  - Granted slot clears unless refilled the same cycle.
- Latency: accepted at edge N -> granted in cycle N+1 -> rf_ld high in cycle N+2 -> register file updated at the edge ending N+2. With no contention there are 2 cycles from acceptance to rf_ld.
- r0 writes: consume a grant slot and clear normally, but rf_ld stays 0 and rf_addr/rf_data are still updated.
- Same address in both slots: written in grant order; the later grant's data is final.
- busy = slot_alu_valid | slot_mem_valid | rf_ld.

Optional Feature:
- Macro: RF_FWD_EN.
- When defined, adds ports:
  - fwd_addr_a in 5, fwd_addr_b in 5;
  - fwd_hit_a out 1, fwd_hit_b out 1;
  - fwd_data_a out 32, fwd_data_b out 32.
- fwd_hit_x = rf_ld && (rf_addr == fwd_addr_x) && (fwd_addr_x != 0); fwd_data_x = rf_data. Both are combinational; fwd_data_x = 0 when there is no hit.
- Purpose: lets read-port logic bypass the write that has not yet landed.
- When undefined: the ports are absent and no compare logic is built.

Test Plan:
- Reset mid-operation: both slots loaded, rst_n low for 1 cycle -> rf_ld=0, rf_addr=0, rf_data=0, readys=0 during reset, busy=0 after; no write to the register file.
- Single ALU write, alu_addr=5, alu_data=0xDEADBEEF, accepted at edge N -> rf_ld=1, rf_addr=5, rf_data=0xDEADBEEF in cycle N+2 only; the register file reads R5=0xDEADBEEF afterward.
- Simultaneous writes: mem (addr 7, 0x11) and ALU (addr 7, 0x22) accepted the same edge -> mem commits in cycle N+2, ALU in N+3; final R7=0x22.
- Starvation, MAX_WAIT=3: mem_valid held high with new addresses every cycle while ALU (addr 9) is pending -> ALU loses 3 cycles, is granted on the 4th, and mem_ready=0 for exactly that one cycle.
- r0 discard: ALU addr 0, data 0xFFFFFFFF -> alu_ready handshake completes and rf_ld stays 0 throughout; back-to-back refill at 1 write/cycle shows no bubbles on rf_ld.
- RF_FWD_EN: rf_ld=1, rf_addr=12, fwd_addr_a=12, fwd_addr_b=0 -> fwd_hit_a=1, fwd_data_a=rf_data, fwd_hit_b=0.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Two-requester writeback arbiter for the register file write port.
// Optional read-bypass compare logic is built when RF_FWD_EN is defined.
module rf_write_arbiter #(
    parameter int unsigned MAX_WAIT = 3,
    parameter int unsigned AW       = 5,
    parameter int unsigned DW       = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [AW-1:0] alu_addr,
    input  logic [DW-1:0] alu_data,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    output logic [AW-1:0] rf_addr,
    output logic [DW-1:0] rf_data,
    output logic          rf_ld,
    output logic          busy
`ifdef RF_FWD_EN
   ,input  logic [AW-1:0] fwd_addr_a,
    input  logic [AW-1:0] fwd_addr_b,
    output logic          fwd_hit_a,
    output logic          fwd_hit_b,
    output logic [DW-1:0] fwd_data_a,
    output logic [DW-1:0] fwd_data_b
`endif
);

    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] MAXW = CW'(MAX_WAIT);

    logic          alu_v_q, mem_v_q;
    logic [AW-1:0] alu_addr_q, mem_addr_q;
    logic [DW-1:0] alu_data_q, mem_data_q;
    logic [CW-1:0] wait_q, wait_d;
    logic [AW-1:0] rf_addr_q;
    logic [DW-1:0] rf_data_q;
    logic          rf_ld_q;

    logic          gnt_alu, gnt_mem;
    logic          alu_acc, mem_acc;
    logic [AW-1:0] gnt_addr;
    logic [DW-1:0] gnt_data;

    // Mem wins ties unless the ALU has already lost MAX_WAIT cycles.
    assign gnt_alu = alu_v_q & (~mem_v_q | (wait_q == MAXW));
    assign gnt_mem = mem_v_q & ~gnt_alu;

    assign alu_ready = rst_n & (~alu_v_q | gnt_alu);
    assign mem_ready = rst_n & (~mem_v_q | gnt_mem);
    assign alu_acc   = alu_valid & alu_ready;
    assign mem_acc   = mem_valid & mem_ready;

    assign gnt_addr = gnt_alu ? alu_addr_q : mem_addr_q;
    assign gnt_data = gnt_alu ? alu_data_q : mem_data_q;

    always_comb begin
        wait_d = '0;
        if (alu_v_q && !gnt_alu)
            wait_d = (wait_q == MAXW) ? wait_q : wait_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_v_q    <= 1'b0;
            mem_v_q    <= 1'b0;
            alu_addr_q <= '0;
            mem_addr_q <= '0;
            alu_data_q <= '0;
            mem_data_q <= '0;
            wait_q     <= '0;
            rf_addr_q  <= '0;
            rf_data_q  <= '0;
            rf_ld_q    <= 1'b0;
        end else begin
            if (alu_acc) begin
                alu_v_q    <= 1'b1;
                alu_addr_q <= alu_addr;
                alu_data_q <= alu_data;
            end else if (gnt_alu) begin
                alu_v_q <= 1'b0;
            end
            if (mem_acc) begin
                mem_v_q    <= 1'b1;
                mem_addr_q <= mem_addr;
                mem_data_q <= mem_data;
            end else if (gnt_mem) begin
                mem_v_q <= 1'b0;
            end
            wait_q <= wait_d;
            // r0 writes still move the address/data registers.
            if (gnt_alu || gnt_mem) begin
                rf_addr_q <= gnt_addr;
                rf_data_q <= gnt_data;
                rf_ld_q   <= |gnt_addr;
            end else begin
                rf_ld_q <= 1'b0;
            end
        end
    end

    assign rf_addr = rf_addr_q;
    assign rf_data = rf_data_q;
    assign rf_ld   = rf_ld_q;
    assign busy    = alu_v_q | mem_v_q | rf_ld_q;

`ifdef RF_FWD_EN
    assign fwd_hit_a  = rf_ld_q & (rf_addr_q == fwd_addr_a) & (|fwd_addr_a);
    assign fwd_hit_b  = rf_ld_q & (rf_addr_q == fwd_addr_b) & (|fwd_addr_b);
    assign fwd_data_a = fwd_hit_a ? rf_data_q : '0;
    assign fwd_data_b = fwd_hit_b ? rf_data_q : '0;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios plus a randomized run
// checked each cycle against a queue-based reference model.
module tb_rf_write_arbiter;

    localparam int MAXW = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid = 1'b0, mem_valid = 1'b0;
    logic        alu_ready, mem_ready;
    logic [4:0]  alu_addr = '0, mem_addr = '0;
    logic [31:0] alu_data = '0, mem_data = '0;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        rf_ld, busy;
`ifdef RF_FWD_EN
    logic [4:0]  fwd_addr_a = '0, fwd_addr_b = '0;
    logic        fwd_hit_a, fwd_hit_b;
    logic [31:0] fwd_data_a, fwd_data_b;
`endif

    rf_write_arbiter #(.MAX_WAIT(MAXW), .AW(5), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .rf_addr(rf_addr), .rf_data(rf_data),
        .rf_ld(rf_ld), .busy(busy)
`ifdef RF_FWD_EN
       ,.fwd_addr_a(fwd_addr_a), .fwd_addr_b(fwd_addr_b),
        .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b),
        .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: each slot is a queue of at most one pending write.
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } req_t;

    req_t        aq[$];
    req_t        mq[$];
    int          lost = 0;
    logic        m_ld = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    logic [31:0] exp_rf [32];
    logic [31:0] dut_rf [32];

    // 0 = nobody, 1 = ALU, 2 = mem
    function automatic int gsel();
        if (aq.size() != 0 && mq.size() != 0)
            return (lost >= MAXW) ? 1 : 2;
        if (aq.size() != 0) return 1;
        if (mq.size() != 0) return 2;
        return 0;
    endfunction

    initial begin
        for (int r = 0; r < 32; r++) begin
            exp_rf[r] = '0;
            dut_rf[r] = '0;
        end
    end

    initial forever begin
        int   g;
        logic ar, mr;
        req_t e;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            aq.delete();
            mq.delete();
            lost   = 0;
            m_ld   = 1'b0;
            m_addr = '0;
            m_data = '0;
        end else begin
            g  = gsel();
            ar = (aq.size() == 0) || (g == 1);
            mr = (mq.size() == 0) || (g == 2);
            if (m_ld) exp_rf[m_addr] = m_data;
            if (aq.size() != 0 && g != 1)
                lost = (lost < MAXW) ? lost + 1 : lost;
            else
                lost = 0;
            if (g != 0) begin
                e = (g == 1) ? aq.pop_front() : mq.pop_front();
                m_addr = e.a;
                m_data = e.d;
                m_ld   = (e.a != 0);
            end else begin
                m_ld = 1'b0;
            end
            if (alu_valid && ar) aq.push_back('{alu_addr, alu_data});
            if (mem_valid && mr) mq.push_back('{mem_addr, mem_data});
        end
    end

    initial forever begin
        int   g;
        logic ar, mr;
        @(negedge clk);
        g  = gsel();
        ar = rst_n && ((aq.size() == 0) || (g == 1));
        mr = rst_n && ((mq.size() == 0) || (g == 2));
        chk("alu_ready", alu_ready, ar);
        chk("mem_ready", mem_ready, mr);
        chk("rf_ld", rf_ld, m_ld);
        chk("rf_addr", rf_addr, m_addr);
        chk("rf_data", rf_data, m_data);
        chk("busy", busy, (aq.size() != 0) || (mq.size() != 0) || m_ld);
`ifdef RF_FWD_EN
        chk("fwd_hit_a", fwd_hit_a, m_ld && m_addr == fwd_addr_a && fwd_addr_a != 0);
        chk("fwd_hit_b", fwd_hit_b, m_ld && m_addr == fwd_addr_b && fwd_addr_b != 0);
        chk("fwd_data_a", fwd_data_a,
            (m_ld && m_addr == fwd_addr_a && fwd_addr_a != 0) ? m_data : 32'h0);
        chk("fwd_data_b", fwd_data_b,
            (m_ld && m_addr == fwd_addr_b && fwd_addr_b != 0) ? m_data : 32'h0);
`endif
        if (rf_ld) dut_rf[rf_addr] = rf_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int first, last, n;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_rf_ld", rf_ld, 0);

        // single ALU write
        tick();
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
        tick();
        alu_valid = 1'b0;
        @(negedge clk); chk("w1_n1_ld", rf_ld, 0);
        tick();
        @(negedge clk);
        chk("w1_n2_ld", rf_ld, 1);
        chk("w1_n2_addr", rf_addr, 5);
        chk("w1_n2_data", rf_data, 32'hDEADBEEF);
        tick();
        @(negedge clk); chk("w1_n3_ld", rf_ld, 0);
        repeat (2) tick();
        chk("w1_r5", dut_rf[5], 32'hDEADBEEF);

        // simultaneous writes to r7
        alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h22;
        mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'h11;
        tick();
        alu_valid = 1'b0; mem_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("sim_n2_ld", rf_ld, 1);
        chk("sim_n2_data", rf_data, 32'h11);
        tick();
        @(negedge clk);
        chk("sim_n3_ld", rf_ld, 1);
        chk("sim_n3_data", rf_data, 32'h22);
        repeat (2) tick();
        chk("sim_r7", dut_rf[7], 32'h22);

        // ALU starvation bound
        alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h99;
        mem_valid = 1'b1; mem_addr = 5'd10; mem_data = 32'h0;
        tick();
        alu_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            mem_addr = 5'(10 + k);
            mem_data = 32'(k);
            @(negedge clk);
            chk("stv_mem_ready", mem_ready, k != 4);
            chk("stv_alu_ready", alu_ready, k == 4);
            tick();
        end
        mem_valid = 1'b0;
        @(negedge clk);
        chk("stv_ld", rf_ld, 1);
        chk("stv_addr", rf_addr, 9);
        chk("stv_data", rf_data, 32'h99);
        repeat (4) tick();

        // r0 writes are discarded
        for (int i = 0; i < 8; i++) begin
            alu_valid = (i < 4); alu_addr = 5'd0; alu_data = 32'hFFFFFFFF;
            @(negedge clk);
            chk("r0_ld", rf_ld, 0);
            chk("r0_ready", alu_ready, 1);
            tick();
        end

        // back-to-back ALU writes: no bubbles
        first = -1; last = -1; n = 0;
        for (int i = 0; i < 8; i++) begin
            alu_valid = (i < 4); alu_addr = 5'(i + 1); alu_data = 32'(100 + i);
            @(negedge clk);
            if (rf_ld) begin
                if (first < 0) first = i;
                last = i;
                n++;
            end
            tick();
        end
        chk("b2b_count", n, 4);
        chk("b2b_span", last - first, 3);
        chk("b2b_first", first, 2);

        // reset mid-operation
        alu_valid = 1'b1; alu_addr = 5'd20; alu_data = 32'hA0;
        mem_valid = 1'b1; mem_addr = 5'd21; mem_data = 32'hB0;
        tick();
        alu_valid = 1'b0; mem_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_alu_ready", alu_ready, 0);
        chk("mrst_mem_ready", mem_ready, 0);
        chk("mrst_ld", rf_ld, 0);
        chk("mrst_addr", rf_addr, 0);
        chk("mrst_data", rf_data, 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk("mrst_no_wr", rf_ld, 0);
        end
        chk("mrst_r20", dut_rf[20], 0);
        chk("mrst_r21", dut_rf[21], 0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst_n     = ($urandom_range(0, 299) != 0);
            alu_valid = ($urandom_range(0, 1) == 1);
            mem_valid = ($urandom_range(0, 3) != 0);
            alu_addr  = 5'($urandom_range(0, 7));
            mem_addr  = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) alu_addr = 5'($urandom);
            if ($urandom_range(0, 3) == 0) mem_addr = 5'($urandom);
            alu_data  = $urandom;
            mem_data  = $urandom;
`ifdef RF_FWD_EN
            fwd_addr_a = 5'($urandom_range(0, 7));
            fwd_addr_b = 5'($urandom_range(0, 7));
`endif
        end
        tick();
        rst_n = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0;
        repeat (10) tick();
        for (int r = 1; r < 32; r++)
            chk($sformatf("final_r%0d", r), dut_rf[r], exp_rf[r]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
